// File: rtl/key_event_encoder.sv
// Turns debounced key levels into PRESS/RELEASE/LONG/REPEAT events, queued in a
// small show-ahead FIFO behind a valid/ready handshake.

module key_fsm #(
  parameter int LONG_PRESS_CYCLES = 50_000_000,
  parameter int REPEAT_CYCLES     = 10_000_000,
  parameter int CW                = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rise,
  input  logic       fall,
  output logic       gen,
  output logic [1:0] etype
);
  localparam logic [1:0] EV_PRESS = 2'b00, EV_RELEASE = 2'b01, EV_LONG = 2'b10, EV_REPEAT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD} state_t;

  state_t        st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= S_IDLE;
      cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

  // Fall is tested first so a release wins over a same-cycle terminal count.
  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    gen     = 1'b0;
    etype   = EV_PRESS;
    case (st)
      S_IDLE: if (rise) begin
        gen     = 1'b1;
        st_nxt  = S_PRESSED;
        cnt_nxt = '0;
      end
      S_PRESSED: begin
        if (fall) begin
          gen = 1'b1; etype = EV_RELEASE; st_nxt = S_IDLE; cnt_nxt = '0;
        end else if (cnt == CW'(LONG_PRESS_CYCLES - 1)) begin
          gen = 1'b1; etype = EV_LONG; st_nxt = S_HELD; cnt_nxt = '0;
        end else cnt_nxt = cnt + 1'b1;
      end
      S_HELD: begin
        if (fall) begin
          gen = 1'b1; etype = EV_RELEASE; st_nxt = S_IDLE; cnt_nxt = '0;
        end else if (cnt == CW'(REPEAT_CYCLES - 1)) begin
          gen = 1'b1; etype = EV_REPEAT; cnt_nxt = '0;
        end else cnt_nxt = cnt + 1'b1;
      end
      default: st_nxt = S_IDLE;
    endcase
  end
endmodule

module key_event_encoder #(
  parameter int LONG_PRESS_CYCLES = 50_000_000,
  parameter int REPEAT_CYCLES     = 10_000_000,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [3:0]                  Keys,
  output logic                        EventValid,
  input  logic                        EventReady,
  output logic [1:0]                  EventKey,
  output logic [1:0]                  EventType,
  output logic [$clog2(FIFO_DEPTH):0] EventCount,
  output logic                        Overflow
);
  localparam int NK   = 4;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int MAXC = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
  localparam int CW   = $clog2(MAXC);

  typedef struct packed {
    logic [1:0] key;
    logic [1:0] etype;
  } evt_t;

  logic [NK-1:0]       kprev, rise, fall, gen, pend_v, drain;
  logic [NK-1:0][1:0]  gtype, pend_t;
  logic                ovf, found, push, pop, full, can_push;
  logic [1:0]          pkey;
  logic [AW-1:0]       wptr, rptr;
  logic [AW:0]         count;
  evt_t                mem [FIFO_DEPTH];
  evt_t                head;

  assign rise = Keys & ~kprev;
  assign fall = ~Keys & kprev;

  always_ff @(posedge Clk) begin
    if (Rst) kprev <= '0;
    else     kprev <= Keys;
  end

  for (genvar i = 0; i < NK; i++) begin : g_key
    key_fsm #(
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .REPEAT_CYCLES    (REPEAT_CYCLES),
      .CW               (CW)
    ) u_fsm (
      .clk  (Clk),
      .rst  (Rst),
      .rise (rise[i]),
      .fall (fall[i]),
      .gen  (gen[i]),
      .etype(gtype[i])
    );
  end

  assign pop      = EventValid & EventReady;
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign can_push = !full || pop;  // a pop on the same edge frees room when full

  always_comb begin
    found = 1'b0;
    pkey  = '0;
    for (int i = 0; i < NK; i++) begin
      if (pend_v[i] && !found) begin
        found = 1'b1;
        pkey  = 2'(i);
      end
    end
    push  = found && can_push;
    drain = push ? (NK'(1) << pkey) : '0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pend_v <= '0;
      pend_t <= '0;
      ovf    <= 1'b0;
    end else begin
      for (int i = 0; i < NK; i++) begin
        if (gen[i]) begin
          if (pend_v[i] && !drain[i]) ovf <= 1'b1;
          else begin
            pend_v[i] <= 1'b1;
            pend_t[i] <= gtype[i];
          end
        end else if (drain[i]) pend_v[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wptr] <= '{key: pkey, etype: pend_t[pkey]};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head fields are masked while empty so the unreset storage never shows.
  assign head       = mem[rptr];
  assign EventValid = (count != '0);
  assign EventKey   = EventValid ? head.key   : 2'b00;
  assign EventType  = EventValid ? head.etype : 2'b00;
  assign EventCount = count;
  assign Overflow   = ovf;
endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder: expected events go into a scoreboard
// queue, a monitor process pops and compares on every accepted FIFO head.

module tb_key_event_encoder;
  logic       Clk, Rst, EventValid, EventReady, Overflow;
  logic [3:0] Keys;
  logic [1:0] EventKey, EventType;
  logic [2:0] EventCount;

  int total, bad;
  logic [3:0] sb [$];

  key_event_encoder #(
    .LONG_PRESS_CYCLES(10),
    .REPEAT_CYCLES    (4),
    .FIFO_DEPTH       (4)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Keys      (Keys),
    .EventValid(EventValid),
    .EventReady(EventReady),
    .EventKey  (EventKey),
    .EventType (EventType),
    .EventCount(EventCount),
    .Overflow  (Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [3:0] ev(int k, int t);
    logic [3:0] r;
    r = {k[1:0], t[1:0]};
    return r;
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic monitor();
    logic [3:0] e;
    forever begin
      @(negedge Clk);
      if (!Rst && EventValid && EventReady) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event: got key=%0d type=%0d expected none", EventKey, EventType);
        end else begin
          e = sb.pop_front();
          if ({EventKey, EventType} !== e) begin
            bad++;
            $display("FAIL event_order: got key=%0d type=%0d expected key=%0d type=%0d",
                     EventKey, EventType, e[3:2], e[1:0]);
          end
        end
      end
    end
  endtask

  initial begin
    int mx;
    total = 0; bad = 0;
    Rst = 1'b1; Keys = 4'b0000; EventReady = 1'b1;
    fork monitor(); join_none
    tick(2);
    Rst = 1'b0;
    chk("rst_valid", EventValid, 0);
    chk("rst_count", EventCount, 0);
    chk("rst_ovf",   Overflow, 0);
    chk("rst_key",   EventKey, 0);
    chk("rst_type",  EventType, 0);

    // key 2 short press
    Keys = 4'b0100; sb.push_back(ev(2, 0));
    tick(1); chk("t1_lat_n",  EventValid, 0);
    tick(1); chk("t1_lat_n1", EventValid, 1);
    tick(1);
    Keys = 4'b0000; sb.push_back(ev(2, 1));
    tick(16); chk("t1_drain", sb.size(), 0);

    // key 0 held 20 cycles: LONG at +10, REPEAT at +14, +18
    Keys = 4'b0001;
    sb.push_back(ev(0, 0)); sb.push_back(ev(0, 2));
    sb.push_back(ev(0, 3)); sb.push_back(ev(0, 3)); sb.push_back(ev(0, 1));
    tick(1);
    tick(10); chk("t2_long_early", EventValid, 0);
    tick(1);  chk("t2_long_v", EventValid, 1); chk("t2_long_t", EventType, 2);
    tick(3);  chk("t2_rep1_early", EventValid, 0);
    tick(1);  chk("t2_rep1_v", EventValid, 1); chk("t2_rep1_t", EventType, 3);
    tick(4);  chk("t2_rep2_v", EventValid, 1); chk("t2_rep2_t", EventType, 3);
    Keys = 4'b0000;
    tick(5); chk("t2_drain", sb.size(), 0);

    // all four keys at one edge
    Keys = 4'b1111;
    for (int k = 0; k < 4; k++) sb.push_back(ev(k, 0));
    mx = 0;
    repeat (7) begin
      tick(1);
      if (int'(EventCount) > mx) mx = int'(EventCount);
    end
    chk("t3_peak", mx, 1);
    Keys = 4'b0000;
    for (int k = 0; k < 4; k++) sb.push_back(ev(k, 1));
    tick(8); chk("t3_drain", sb.size(), 0);
    chk("t3_ovf", Overflow, 0);

    // consumer stalled, key 1 toggled for 12 events
    EventReady = 1'b0;
    for (int i = 0; i < 12; i++) begin
      Keys = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      tick(1);
    end
    chk("t4_count_full", EventCount, 4);
    chk("t4_ovf", Overflow, 1);
    for (int i = 0; i < 5; i++) sb.push_back(ev(1, i % 2));
    EventReady = 1'b1;
    tick(1); chk("t5_pop_push", EventCount, 4);
    tick(1); chk("t5_pop_only", EventCount, 3);
    tick(6); chk("t4_drain", sb.size(), 0);
    chk("t4_ovf_sticky", Overflow, 1);

    // reset with events queued and key 3 held through it
    EventReady = 1'b0;
    Keys = 4'b0111;
    tick(4); chk("t6_queued", EventCount, 3);
    Keys = 4'b1000; Rst = 1'b1;
    tick(1);
    Rst = 1'b0;
    chk("t6_valid", EventValid, 0);
    chk("t6_count", EventCount, 0);
    chk("t6_ovf",   Overflow, 0);
    chk("t6_key",   EventKey, 0);
    chk("t6_type",  EventType, 0);
    sb.delete();
    sb.push_back(ev(3, 0));
    EventReady = 1'b1;
    tick(1); chk("t6_lat_n", EventValid, 0);
    tick(1); chk("t6_first_v", EventValid, 1); chk("t6_first_k", EventKey, 3);
    Keys = 4'b0000; sb.push_back(ev(3, 1));
    tick(5); chk("t6_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
